// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - opcode constants, masks and fetch state enum shared by fetch and decode
package fetch_stage_pkg;

  localparam int INSTR_DATA_W = 16;
  localparam int OPC_HI       = 15;
  localparam int OPC_LO       = 9;
  localparam int OPC_W        = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] OPC_IADD  = 7'b0101000;
  localparam logic [OPC_W-1:0] MASK_IADD = 7'b1111111;
  localparam logic [OPC_W-1:0] OPC_LDM   = 7'b0111000;
  localparam logic [OPC_W-1:0] MASK_LDM  = 7'b1111000;
  localparam logic [OPC_W-1:0] OPC_LDD   = 7'b1010000;
  localparam logic [OPC_W-1:0] MASK_LDD  = 7'b1111000;
  localparam logic [OPC_W-1:0] OPC_STD   = 7'b1011000;
  localparam logic [OPC_W-1:0] MASK_STD  = 7'b1111000;
  localparam logic [OPC_W-1:0] OPC_HLT   = 7'b0000100;
  localparam logic [OPC_W-1:0] MASK_HLT  = 7'b1111100;

  typedef enum logic [2:0] {
    VEC_LO,
    VEC_HI,
    FETCH,
    IMM,
    HALT
  } fetch_state_t;

  function automatic logic opc_match(input logic [OPC_W-1:0] opc,
                                     input logic [OPC_W-1:0] val,
                                     input logic [OPC_W-1:0] mask);
    return (opc & mask) == val;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory, redirect/stall and IF/ID bundle of the fetch stage
interface fetch_stage_if import fetch_stage_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = INSTR_DATA_W
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_imm;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;

  modport master (
    output imem_addr, if_valid, if_instr, if_imm, if_pc, halted,
    input  imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_imm, if_pc, halted,
    output imem_rdata, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_len_decode.sv
// rtl/instr_len_decode.sv - flags opcodes that carry a trailing immediate word
module instr_len_decode import fetch_stage_pkg::*; (
  input  logic [OPC_W-1:0] opcode,
  output logic             two_word
);
  assign two_word = opc_match(opcode, OPC_IADD, MASK_IADD) |
                    opc_match(opcode, OPC_LDM,  MASK_LDM)  |
                    opc_match(opcode, OPC_LDD,  MASK_LDD)  |
                    opc_match(opcode, OPC_STD,  MASK_STD);
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: reset vector load, 1/2-word assembly, redirect flush
// Optional HALT state on HLT opcodes is built when FETCH_HLT_EN is defined.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = INSTR_DATA_W,
  parameter logic [ADDR_W-1:0] VEC_ADDR = '0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, hpc, hpc_n, out_pc, out_pc_n, vec_pc;
  logic [DATA_W-1:0] lo, lo_n, hold, hold_n, out_instr, out_instr_n, out_imm, out_imm_n;
  logic              out_valid, out_valid_n, two_word;
  logic [OPC_W-1:0]  opcode;
  logic [2*DATA_W-1:0] vec_word;

  assign opcode   = bus.imem_rdata[OPC_HI:OPC_LO];
  assign vec_word = {bus.imem_rdata, lo};

  instr_len_decode u_len (
    .opcode   (opcode),
    .two_word (two_word)
  );

  generate
    if (ADDR_W > 2*DATA_W) begin : g_vec_zext
      assign vec_pc = {{(ADDR_W-2*DATA_W){1'b0}}, vec_word};
    end else begin : g_vec_trunc
      assign vec_pc = vec_word[ADDR_W-1:0];
    end
  endgenerate

`ifdef FETCH_HLT_EN
  logic is_hlt;
  assign is_hlt     = opc_match(opcode, OPC_HLT, MASK_HLT);
  assign bus.halted = (state == HALT);
`else
  assign bus.halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= VEC_LO;
      pc        <= VEC_ADDR;
      lo        <= '0;
      hold      <= '0;
      hpc       <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      lo        <= lo_n;
      hold      <= hold_n;
      hpc       <= hpc_n;
      out_valid <= out_valid_n;
      out_instr <= out_instr_n;
      out_imm   <= out_imm_n;
      out_pc    <= out_pc_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    lo_n        = lo;
    hold_n      = hold;
    hpc_n       = hpc;
    out_valid_n = out_valid;
    out_instr_n = out_instr;
    out_imm_n   = out_imm;
    out_pc_n    = out_pc;
    // A flush beats a stall, but only once the vector is loaded and never out of HALT.
    if (bus.redirect_valid && (state == FETCH || state == IMM)) begin
      pc_n        = bus.redirect_pc;
      out_valid_n = 1'b0;
      state_n     = FETCH;
    end else if (!bus.stall) begin
      case (state)
        VEC_LO: begin
          lo_n    = bus.imem_rdata;
          pc_n    = pc + PC_ONE;
          state_n = VEC_HI;
        end
        VEC_HI: begin
          pc_n    = vec_pc;
          state_n = FETCH;
        end
        FETCH: begin
          pc_n = pc + PC_ONE;
          if (two_word) begin
            hold_n      = bus.imem_rdata;
            hpc_n       = pc;
            out_valid_n = 1'b0;
            state_n     = IMM;
          end else begin
            out_instr_n = bus.imem_rdata;
            out_imm_n   = '0;
            out_pc_n    = pc;
            out_valid_n = 1'b1;
`ifdef FETCH_HLT_EN
            if (is_hlt) state_n = HALT;
`endif
          end
        end
        IMM: begin
          out_instr_n = hold;
          out_imm_n   = bus.imem_rdata;
          out_pc_n    = hpc;
          out_valid_n = 1'b1;
          pc_n        = pc + PC_ONE;
          state_n     = FETCH;
        end
`ifdef FETCH_HLT_EN
        HALT: begin
          out_valid_n = 1'b0;
        end
`endif
        default: begin
          state_n = VEC_LO;
        end
      endcase
    end
  end

  assign bus.imem_addr = pc;
  assign bus.if_valid  = out_valid;
  assign bus.if_instr  = out_instr;
  assign bus.if_imm    = out_imm;
  assign bus.if_pc     = out_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (HALT checks when FETCH_HLT_EN is defined)
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] instr;
    logic [15:0] imm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   mon_en;
  int   mem_gen;
  exp_t exp_q[$];
  logic [15:0] mem [logic [31:0]];

  fetch_stage_if #(.ADDR_W(32), .DATA_W(16)) bus ();

  fetch_stage #(.ADDR_W(32), .DATA_W(16), .VEC_ADDR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(bus.imem_addr or mem_gen)
    bus.imem_rdata = mem.exists(bus.imem_addr) ? mem[bus.imem_addr] : 16'h0000;

  // An instruction is consumed on any edge where it is valid and not stalled.
  always @(negedge clk) begin
    if (mon_en && rst_n && bus.if_valid && !bus.stall) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h imm=%h, required no instruction",
                 bus.if_pc, bus.if_instr, bus.if_imm);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.if_pc !== e.pc || bus.if_instr !== e.instr || bus.if_imm !== e.imm) begin
          bad++;
          $display("FAIL sb_instr: got pc=%h instr=%h imm=%h, required pc=%h instr=%h imm=%h",
                   bus.if_pc, bus.if_instr, bus.if_imm, e.pc, e.instr, e.imm);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_w(input logic [31:0] a, input logic [15:0] d);
    mem[a] = d;
    mem_gen++;
  endtask

  task automatic push(input logic [31:0] pc, input logic [15:0] instr, input logic [15:0] imm);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.imm = imm;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc, bus.halted, bus.imem_addr} !==
        {1'b0, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_values: got v=%b instr=%h imm=%h pc=%h halted=%b addr=%h, required all zero",
               bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc, bus.halted, bus.imem_addr);
    end
    exp_q.delete();
    mem.delete();
    mem_gen++;
  endtask

  task automatic release_reset();
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_reset_vector();
    do_reset();
    mem_w(32'h0, 16'h0010);
    mem_w(32'h1, 16'h0000);
    mem_w(32'h10, 16'h0000);
    push(32'h10, 16'h0000, 16'h0000);
    release_reset();
    tick();
    total++;
    if (bus.imem_addr !== 32'h1) begin
      bad++; $display("FAIL vec_hi_addr: got %h, required 00000001", bus.imem_addr);
    end
    tick();
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h10) begin
      bad++; $display("FAIL vec_jump: got v=%b addr=%h, required v=0 addr=00000010", bus.if_valid, bus.imem_addr);
    end
    tick();
    total++;
    if (bus.if_valid !== 1'b1) begin
      bad++; $display("FAIL first_valid_cycle3: got %b, required 1", bus.if_valid);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_reset_vector: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_two_word_stall();
    do_reset();
    mem_w(32'h0, 16'h0010);
    mem_w(32'h10, 16'h7000);
    mem_w(32'h11, 16'hBEEF);
    mem_w(32'h12, 16'h1200);
    mem_w(32'h13, 16'h1300);
    push(32'h10, 16'h7000, 16'hBEEF);
    push(32'h12, 16'h1200, 16'h0000);
    push(32'h13, 16'h1300, 16'h0000);
    release_reset();
    repeat (3) tick();
    total++;
    if (bus.if_valid !== 1'b0) begin
      bad++; $display("FAIL ldm_gap: got v=%b, required 0", bus.if_valid);
    end
    tick();
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h10) begin
      bad++; $display("FAIL ldm_out: got v=%b pc=%h, required v=1 pc=00000010", bus.if_valid, bus.if_pc);
    end
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr} !== {1'b1, 32'h12, 16'h1200, 32'h13}) begin
        bad++;
        $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h, required 1/00000012/1200/00000013",
                 i, bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr);
      end
    end
    bus.stall = 1'b0;
    tick();
    total++;
    if (bus.if_pc !== 32'h13) begin
      bad++; $display("FAIL stall_release: got pc=%h, required 00000013", bus.if_pc);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_two_word: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_w(32'h0, 16'h0010);
    mem_w(32'h10, 16'h5000);
    mem_w(32'h11, 16'h1111);
    mem_w(32'h40, 16'hA000);
    mem_w(32'h41, 16'h2222);
    mem_w(32'h50, 16'h1500);
    push(32'h50, 16'h1500, 16'h0000);
    release_reset();
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
      bad++; $display("FAIL redirect_imm: got v=%b addr=%h, required v=0 addr=00000040", bus.if_valid, bus.imem_addr);
    end
    tick();
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h41) begin
      bad++; $display("FAIL ldd_opcode: got v=%b addr=%h, required v=0 addr=00000041", bus.if_valid, bus.imem_addr);
    end
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h50;
    tick();
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h50) begin
      bad++; $display("FAIL redirect_over_stall: got v=%b addr=%h, required v=0 addr=00000050", bus.if_valid, bus.imem_addr);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_redirect: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_w(32'h0, 16'h0010);
    mem_w(32'h10, 16'h1000);
    mem_w(32'hFFFF_FFFF, 16'hB000);
    push(32'hFFFF_FFFF, 16'hB000, 16'h1234);
    push(32'h1, 16'h0000, 16'h0000);
    release_reset();
    repeat (2) tick();
    mem_w(32'h0, 16'h1234);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL redirect_fetch: got v=%b addr=%h, required v=0 addr=ffffffff", bus.if_valid, bus.imem_addr);
    end
    tick();
    total++;
    if (bus.imem_addr !== 32'h0) begin
      bad++; $display("FAIL pc_wrap: got addr=%h, required 00000000", bus.imem_addr);
    end
    tick();
    total++;
    if (bus.imem_addr !== 32'h1) begin
      bad++; $display("FAIL after_wrap: got addr=%h, required 00000001", bus.imem_addr);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_wrap: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic load_hlt_prog();
    mem_w(32'h0, 16'h0020);
    mem_w(32'h20, 16'h0800);
    mem_w(32'h21, 16'h1200);
    push(32'h20, 16'h0800, 16'h0000);
  endtask

  task automatic test_halt();
    do_reset();
    load_hlt_prog();
`ifndef FETCH_HLT_EN
    push(32'h21, 16'h1200, 16'h0000);
`endif
    release_reset();
    repeat (3) tick();
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h20 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL hlt_emit: got v=%b pc=%h halted=%b, required 1/00000020/0", bus.if_valid, bus.if_pc, bus.halted);
    end
    tick();
`ifdef FETCH_HLT_EN
    total++;
    if ({bus.if_valid, bus.halted, bus.imem_addr} !== {1'b0, 1'b1, 32'h21}) begin
      bad++; $display("FAIL halt_state: got v=%b halted=%b addr=%h, required 0/1/00000021", bus.if_valid, bus.halted, bus.imem_addr);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    total++;
    if ({bus.if_valid, bus.halted, bus.imem_addr} !== {1'b0, 1'b1, 32'h21}) begin
      bad++; $display("FAIL halt_redirect: got v=%b halted=%b addr=%h, required 0/1/00000021", bus.if_valid, bus.halted, bus.imem_addr);
    end
    do_reset();
    load_hlt_prog();
    release_reset();
    repeat (3) tick();
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h20) begin
      bad++; $display("FAIL halt_reload: got v=%b pc=%h, required 1/00000020", bus.if_valid, bus.if_pc);
    end
`else
    total++;
    if ({bus.if_valid, bus.halted, bus.if_pc} !== {1'b1, 1'b0, 32'h21}) begin
      bad++; $display("FAIL hlt_plain: got v=%b halted=%b pc=%h, required 1/0/00000021", bus.if_valid, bus.halted, bus.if_pc);
    end
`endif
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_halt: %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    mem_gen = 0;
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    #2;
    test_reset_vector();
    test_two_word_stall();
    test_redirect();
    test_wrap();
    test_halt();
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
